// File: rtl/scan_frame_writer_pkg.sv
// Shared widths and FSM encoding for the scan frame writer.
// Also holds the ZBT0 address helper used by the write stage.
package scan_frame_writer_pkg;

    localparam int PIXEL_W      = 9;
    localparam int PIX_PER_WORD = 4;
    localparam int ZBT_DATA_W   = 36;
    localparam int ZBT_ADDR_W   = 19;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Word address relative to the frame base; the add wraps modulo 2^19.
    function automatic logic [ZBT_ADDR_W-1:0] word_addr(
        input logic [ZBT_ADDR_W-1:0] base,
        input logic [ZBT_ADDR_W-1:0] idx
    );
        return base + idx;
    endfunction

endpackage

// File: rtl/scan_frame_writer_word_fifo.sv
// Show-ahead synchronous FIFO for packed ZBT0 words; head is valid whenever not empty.
// Push into a full FIFO is only taken when a pop happens in the same cycle.
module word_fifo
    import scan_frame_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ZBT_DATA_W-1:0] push_data,
    input  logic                  pop,
    output logic [ZBT_DATA_W-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [ZBT_DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scan_frame_writer.sv
// Packs a 9-bit pixel stream four pixels per 36-bit word and writes the words to
// sequential ZBT0 addresses during arbiter write slots, one frame per frame_start.
module scan_frame_writer
    import scan_frame_writer_pkg::*;
#(
    parameter int                    FRAME_WORDS = 76800,
    parameter logic [ZBT_ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pixel_valid,
    input  logic [PIXEL_W-1:0]    pixel_data,
    output logic                  pixel_ready,
    input  logic                  wr_slot,
    output logic [ZBT_ADDR_W-1:0] zbt0_write_addr,
    output logic [ZBT_DATA_W-1:0] zbt0_write_data,
    output logic                  zbt0_we,
    output logic                  frame_done,
    output logic                  frame_dropped
);

    localparam int                    TOTAL_PIX = PIX_PER_WORD * FRAME_WORDS;
    localparam int                    PIX_CNT_W = (TOTAL_PIX > 1) ? $clog2(TOTAL_PIX) : 1;
    localparam logic [PIX_CNT_W-1:0]  LAST_PIX  = PIX_CNT_W'(TOTAL_PIX - 1);
    localparam logic [ZBT_ADDR_W-1:0] LAST_WORD = ZBT_ADDR_W'(FRAME_WORDS - 1);

    state_t                      state;
    logic [1:0]                  pack_count;
    logic [PIX_CNT_W-1:0]        pix_count;
    logic [ZBT_ADDR_W-1:0]       word_count;
    logic [3*PIXEL_W-1:0]        pack_buf;

    logic                        accept;
    logic                        push_p0;
    logic                        pop_p0;
    logic [ZBT_DATA_W-1:0]       word_p0;
    logic [ZBT_DATA_W-1:0]       head;
    logic                        fifo_full;
    logic                        fifo_empty;

    logic                        vld_p1;
    logic [ZBT_DATA_W-1:0]       data_p1;
    logic [ZBT_ADDR_W-1:0]       addr_p1;

    // Stage p0: pixel acceptance, packing and FIFO push/pop decisions.
    assign pixel_ready = (state == ST_CAPTURE) & ~((pack_count == 2'd3) & fifo_full);
    assign accept      = pixel_valid & pixel_ready;
    assign push_p0     = accept & (pack_count == 2'd3);
    assign word_p0     = {pack_buf, pixel_data};
    assign pop_p0      = wr_slot & ~fifo_empty;

    // The first three pixels of a group shift in; the fourth completes the word directly.
    always_ff @(posedge clk) begin
        if (accept) begin
            pack_buf <= {pack_buf[2*PIXEL_W-1:0], pixel_data};
        end
    end

    word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_p0),
        .push_data (word_p0),
        .pop       (pop_p0),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            pack_count    <= '0;
            pix_count     <= '0;
            frame_done    <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start && (state != ST_IDLE)) begin
                frame_dropped <= 1'b1;
            end
            if (accept) begin
                pack_count <= pack_count + 2'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state     <= ST_CAPTURE;
                        pix_count <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        if (pix_count == LAST_PIX) begin
                            state     <= ST_FLUSH;
                            pix_count <= '0;
                        end else begin
                            pix_count <= pix_count + 1'b1;
                        end
                    end
                end
                // Empty here means the last pop already happened at the previous edge.
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage p1: registered ZBT0 write, address taken from the word count at issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            addr_p1    <= BASE_ADDR;
            word_count <= '0;
        end else begin
            vld_p1 <= pop_p0;
            if (pop_p0) begin
                data_p1    <= head;
                addr_p1    <= word_addr(BASE_ADDR, word_count);
                word_count <= (word_count == LAST_WORD) ? '0 : word_count + 1'b1;
            end
        end
    end

    assign zbt0_we         = vld_p1;
    assign zbt0_write_data = data_p1;
    assign zbt0_write_addr = addr_p1;

endmodule

// File: tb/tb_scan_frame_writer.sv
// Directed-plus-random bench for scan_frame_writer against a queue-based frame model.
module tb_scan_frame_writer;

    localparam int          FW    = 6;
    localparam int          DEPTH = 4;
    localparam logic [18:0] BASE  = 19'h7FFFE;
    localparam int          TOTAL = 4 * FW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [8:0]  pixel_data = '0;
    logic        wr_slot = 1'b0;
    logic        pixel_ready;
    logic [18:0] zbt0_write_addr;
    logic [35:0] zbt0_write_data;
    logic        zbt0_we;
    logic        frame_done;
    logic        frame_dropped;

    int checks = 0;
    int errors = 0;

    // Reference model: frame phase, pixel group, queued words with their target addresses.
    bit          m_armed;
    bit          m_done_cyc;
    int          m_pix;
    int          m_widx;
    logic [8:0]  m_grp[$];
    logic [35:0] m_fifo_d[$];
    logic [18:0] m_fifo_a[$];
    logic        m_we;
    logic [35:0] m_data;
    logic [18:0] m_addr;
    logic        m_done;
    logic        m_dropped;
    int          obs_writes;

    scan_frame_writer #(
        .FRAME_WORDS (FW),
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .pixel_valid     (pixel_valid),
        .pixel_data      (pixel_data),
        .pixel_ready     (pixel_ready),
        .wr_slot         (wr_slot),
        .zbt0_write_addr (zbt0_write_addr),
        .zbt0_write_data (zbt0_write_data),
        .zbt0_we         (zbt0_we),
        .frame_done      (frame_done),
        .frame_dropped   (frame_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed    = 1'b0;
        m_done_cyc = 1'b0;
        m_pix      = 0;
        m_widx     = 0;
        m_grp.delete();
        m_fifo_d.delete();
        m_fifo_a.delete();
        m_we       = 1'b0;
        m_data     = '0;
        m_addr     = BASE;
        m_done     = 1'b0;
        m_dropped  = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        bit          exp_ready;
        bit          acc;
        bit          pop;
        bit          done_now;
        bit          slot_at_issue;
        logic [35:0] w;
        logic [18:0] a;
        exp_ready = m_armed && (m_pix < TOTAL) &&
                    !((m_grp.size() == 3) && (m_fifo_d.size() == DEPTH));
        chk("pixel_ready", 64'(pixel_ready), 64'(exp_ready));
        acc      = pixel_valid && exp_ready;
        pop      = wr_slot && (m_fifo_d.size() > 0);
        done_now = m_armed && (m_pix == TOTAL) && (m_fifo_d.size() == 0);
        m_we = pop;
        if (pop) begin
            m_data = m_fifo_d.pop_front();
            m_addr = m_fifo_a.pop_front();
        end
        if (acc) begin
            m_grp.push_back(pixel_data);
            m_pix++;
            if (m_grp.size() == 4) begin
                w = {m_grp[0], m_grp[1], m_grp[2], m_grp[3]};
                a = BASE + 19'(m_widx % FW);
                m_fifo_d.push_back(w);
                m_fifo_a.push_back(a);
                m_widx++;
                m_grp.delete();
            end
        end
        m_done = done_now;
        if (frame_start) begin
            if (!m_armed && !m_done_cyc) begin
                m_armed = 1'b1;
                m_pix   = 0;
            end else begin
                m_dropped = 1'b1;
            end
        end
        if (done_now) m_armed = 1'b0;
        m_done_cyc    = done_now;
        slot_at_issue = wr_slot;
        @(posedge clk);
        #1;
        chk("zbt0_we", 64'(zbt0_we), 64'(m_we));
        chk("zbt0_write_data", 64'(zbt0_write_data), 64'(m_data));
        chk("zbt0_write_addr", 64'(zbt0_write_addr), 64'(m_addr));
        chk("frame_done", 64'(frame_done), 64'(m_done));
        chk("frame_dropped", 64'(frame_dropped), 64'(m_dropped));
        if (zbt0_we) begin
            obs_writes++;
            chk("we_without_slot", 64'(slot_at_issue), 64'd1);
        end
        @(negedge clk);
    endtask

    // mode: 0 slot always on, 1 toggling, 2 random, 3 slot off
    task automatic drive(input int mode, input int vpct);
        pixel_valid = ($urandom_range(99) < vpct);
        pixel_data  = 9'($urandom);
        case (mode)
            0:       wr_slot = 1'b1;
            1:       wr_slot = ~wr_slot;
            2:       wr_slot = 1'($urandom);
            default: wr_slot = 1'b0;
        endcase
    endtask

    task automatic start_frame(input int mode);
        obs_writes  = 0;
        frame_start = 1'b1;
        drive(mode, 50);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_to_idle(input int mode, input int vpct);
        int n;
        n = 0;
        while ((m_armed || m_done_cyc) && (n < 1000)) begin
            drive(mode, vpct);
            tick();
            n++;
        end
        chk("frame_complete", 64'(m_armed || m_done_cyc), 64'd0);
        chk("writes_per_frame", 64'(obs_writes), 64'(FW));
    endtask

    initial begin
        model_reset();
        obs_writes = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", 64'(zbt0_we), 64'd0);
        chk("rst_addr", 64'(zbt0_write_addr), 64'(BASE));
        chk("rst_data", 64'(zbt0_write_data), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_dropped", 64'(frame_dropped), 64'd0);
        chk("rst_ready", 64'(pixel_ready), 64'd0);
        reset = 1'b0;
        tick();

        // Pixels 1..4 with the slot open: word lands two cycles after pixel 4.
        start_frame(0);
        for (int i = 1; i <= 4; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 9'(i);
            wr_slot     = 1'b1;
            tick();
        end
        pixel_valid = 1'b0;
        tick();
        chk("t1_we", 64'(zbt0_we), 64'd1);
        chk("t1_addr", 64'(zbt0_write_addr), 64'(BASE));
        chk("t1_data", 64'(zbt0_write_data), 64'({9'd1, 9'd2, 9'd3, 9'd4}));
        run_to_idle(0, 100);

        // Slot held off: FIFO fills, a fourth pixel cannot be packed, then drains.
        start_frame(3);
        for (int i = 0; i < 40; i++) begin
            drive(3, 100);
            tick();
        end
        chk("t3_stall_ready", 64'(pixel_ready), 64'd0);
        run_to_idle(0, 100);

        start_frame(1);
        run_to_idle(1, 70);

        // Second frame_start during capture is dropped and sticky.
        start_frame(2);
        for (int i = 0; i < 8; i++) begin
            drive(2, 80);
            tick();
        end
        frame_start = 1'b1;
        drive(2, 80);
        tick();
        frame_start = 1'b0;
        chk("t5_dropped", 64'(frame_dropped), 64'd1);
        run_to_idle(2, 80);

        // Reset mid-frame with a write on the bus.
        start_frame(3);
        for (int i = 0; i < 6; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 9'($urandom);
            wr_slot     = 1'b0;
            tick();
        end
        pixel_valid = 1'b0;
        wr_slot     = 1'b1;
        tick();
        chk("t6_we_before_reset", 64'(zbt0_we), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_we_async", 64'(zbt0_we), 64'd0);
        chk("t6_addr_async", 64'(zbt0_write_addr), 64'(BASE));
        chk("t6_dropped_cleared", 64'(frame_dropped), 64'd0);
        chk("t6_ready_async", 64'(pixel_ready), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        obs_writes = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 100);
            tick();
        end
        chk("t6_no_write_after_reset", 64'(obs_writes), 64'd0);
        start_frame(2);
        run_to_idle(2, 75);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
